data_rx_ctrl: RTL
=================

DATA_RX_CTRL -- requirements
Module: data_rx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port rx_byte, input, 8 bits: received packet byte.
REQ-004 SHALL have port rx_valid, input, 1 bit: rx_byte valid this cycle.
REQ-005 SHALL have port rx_eop, input, 1 bit: qualified by rx_valid; marks the last byte of a packet.
REQ-006 SHALL have port data, output, 1024 bits: assembled payload, first payload byte in data[1023:1016].
REQ-007 SHALL have port data_valid, output, 1 bit: data holds a new, good, in-sequence payload.
REQ-008 SHALL have port data_ready, input, 1 bit: consumer accepts data when data_valid and data_ready are both high.
REQ-009 SHALL have port ack, output, 1 bit: one-cycle handshake pulse for a good packet.
REQ-010 SHALL have port nak, output, 1 bit: one-cycle handshake pulse for a bad packet.
REQ-011 SHALL have port data_error, output, 1 bit: one-cycle pulse for a CRC, length or overrun fault.
REQ-012 SHALL have port expected_toggle, output, 1 bit: 0 expects DATA0, 1 expects DATA1.
REQ-013 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-014 SHALL accept packets of 131 bytes: PID, 128 payload bytes, CRC high byte, CRC low byte (CRC low carries rx_eop).
REQ-015 SHALL recognise PID_DATA0 = 8'h3C and PID_DATA1 = 8'hB4; any other PID SHALL go to DROP, discard bytes through rx_eop, and produce no pulses.
REQ-016 SHALL use FSM states IDLE, PAYLOAD, CRC_HI, CRC_LO, CHECK, HOLD, DROP; the PID byte SHALL be consumed in IDLE.
REQ-017 SHALL ignore cycles with rx_valid low in every state, with no state or counter change.
REQ-018 SHALL count payload bytes with a 7-bit counter; PAYLOAD SHALL exit to CRC_HI after the byte sampled at count 127.
REQ-019 SHALL update CRC16 once per payload byte only: polynomial x^16+x^15+x^2+1, init 16'h0000, MSB first, no final inversion.
REQ-020 SHALL enter CHECK for exactly one cycle and compare computed CRC to {CRC_HI, CRC_LO}.
REQ-021 On a rx_eop earlier than the CRC low byte, SHALL pulse data_error and nak, then return to IDLE.
REQ-022 If rx_eop is absent on the CRC low byte, SHALL enter DROP, then pulse data_error and nak on the cycle after the rx_eop byte.
REQ-023 On CRC mismatch, SHALL pulse data_error and nak, leave data_valid low, and keep expected_toggle unchanged.
REQ-024 On CRC match with the PID toggle equal to expected_toggle, SHALL pulse ack, raise data_valid, invert expected_toggle, and enter HOLD.
REQ-025 On CRC match with a mismatched toggle (duplicate packet), SHALL pulse ack only, with data and toggle unchanged.
REQ-026 The ack, nak, data_error and data_valid rise SHALL be registered and appear 2 clock edges after the edge that samples the last CRC byte.
REQ-027 In HOLD, data_valid and data SHALL stay stable until data_ready; on the accepting edge data_valid SHALL drop and the FSM SHALL return to IDLE.
REQ-028 In HOLD, rx bytes SHALL be discarded without response; busy SHALL stay high.
REQ-029 The ack and nak outputs SHALL never be high in the same cycle.

Reset
REQ-030 Reset SHALL force IDLE, clear the counter and CRC register, set data, data_valid, ack, nak, data_error and expected_toggle to 0, and drive busy low.
REQ-031 Reset during a packet or HOLD SHALL abort it with no pulse; bytes after reset deasserts SHALL be treated as a new PID.

Structure
REQ-032 The PID_DATA0, PID_DATA1, PAYLOAD_BYTES=128, CRC16_INIT and state encodings SHALL live in shared Defintions.v.
REQ-033 The byte-wide CRC update SHALL be a combinational sub-module crc16_d8 (inputs data[7:0] and crc[15:0], output next_crc[15:0]).

Verification
REQ-034 Reset, then DATA0 PID + 128 bytes 8'h00 + CRC 8'h00, 8'h00 with rx_eop -> ack and data_valid after 2 edges, data = 0, expected_toggle 1, and HOLD until data_ready.
REQ-035 Send a good packet, then repeat the same DATA0 packet with expected_toggle = 1 -> ack only, data_valid low, expected_toggle stays 1.
REQ-036 Send a zero-payload DATA0 packet with CRC 8'h12, 8'h34 -> data_error and nak one cycle each, data_valid low, expected_toggle 0.
REQ-037 Send PID 8'h69 + 10 bytes with rx_eop -> no pulses, back to IDLE, busy low.
REQ-038 Assert rx_eop on payload byte 50 -> data_error and nak; assert reset mid-payload -> no pulses, outputs 0.
REQ-039 Hold rx_valid low for random gaps inside a good packet -> same result as REQ-034.

Source files
------------

// File: rtl/data_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_rx_ctrl_pkg
// Shared definitions for the data packet receive controller. It holds the PID
// values, the payload geometry, the CRC16 parameters and the FSM state
// encoding, so the controller and the CRC sub-module use the same values.
// -----------------------------------------------------------------------------
package data_rx_ctrl_pkg;

   localparam logic [7:0]  PID_DATA0     = 8'h3C;
   localparam logic [7:0]  PID_DATA1     = 8'hB4;

   localparam int          PAYLOAD_BYTES = 128;
   localparam int          PAYLOAD_BITS  = PAYLOAD_BYTES * 8;
   localparam logic [6:0]  LAST_PAYLOAD  = 7'(PAYLOAD_BYTES - 1);

   // x^16 + x^15 + x^2 + 1, shifted MSB first
   localparam logic [15:0] CRC16_INIT    = 16'h0000;
   localparam logic [15:0] CRC16_POLY    = 16'h8005;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAYLOAD = 3'd1,
      ST_CRC_HI  = 3'd2,
      ST_CRC_LO  = 3'd3,
      ST_CHECK   = 3'd4,
      ST_HOLD    = 3'd5,
      ST_DROP    = 3'd6
   } state_t;

   function automatic logic is_data_pid(input logic [7:0] pid);
      return (pid == PID_DATA0) || (pid == PID_DATA1);
   endfunction

endpackage

// File: rtl/data_rx_ctrl_crc16_d8.sv
// -----------------------------------------------------------------------------
// crc16_d8
// Combinational byte-wide CRC16 step (x^16+x^15+x^2+1), MSB of the byte
// first, no reflection and no final inversion.
//
// Ports
//   data     : input byte
//   crc      : current CRC register value
//   next_crc : CRC after absorbing the byte
// -----------------------------------------------------------------------------
module crc16_d8
   import data_rx_ctrl_pkg::*;
(
   input  logic [7:0]  data,
   input  logic [15:0] crc,
   output logic [15:0] next_crc
);

   logic fb;

   always_comb begin
      next_crc = crc;
      fb       = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb       = next_crc[15] ^ data[i];
         next_crc = {next_crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/data_rx_ctrl.sv
// -----------------------------------------------------------------------------
// data_rx_ctrl
// Receives DATA0/DATA1 packets (PID, 128 payload bytes, CRC hi, CRC lo),
// checks the CRC16 and the data toggle, and hands good in-sequence payloads
// to a consumer through a valid/ready pair. Handshake pulses report the
// result of every packet with a recognised PID.
//
// Ports
//   clk             : rising-edge clock
//   reset           : synchronous active-high reset
//   rx_byte         : received byte
//   rx_valid        : rx_byte valid this cycle
//   rx_eop          : last byte of packet (qualified by rx_valid)
//   data            : assembled payload, first byte in data[1023:1016]
//   data_valid      : data holds a new good payload
//   data_ready      : consumer accepts data when data_valid is high
//   ack             : one-cycle pulse, good packet (new or duplicate)
//   nak             : one-cycle pulse, bad packet
//   data_error      : one-cycle pulse, CRC / length / overrun fault
//   expected_toggle : 0 expects DATA0, 1 expects DATA1
//   busy            : FSM is not in IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a PID byte
// PAYLOAD | collecting 128 payload bytes, CRC running
// CRC_HI  | waiting for CRC high byte
// CRC_LO  | waiting for CRC low byte, which must carry rx_eop
// CHECK   | one cycle: compare CRC and toggle, decide result
// HOLD    | payload presented, waiting for data_ready
// DROP    | discarding bytes through rx_eop (unknown PID or overrun)
// -----------------------------------------------------------------------------
module data_rx_ctrl
   import data_rx_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_byte,
   input  logic                    rx_valid,
   input  logic                    rx_eop,
   output logic [PAYLOAD_BITS-1:0] data,
   output logic                    data_valid,
   input  logic                    data_ready,
   output logic                    ack,
   output logic                    nak,
   output logic                    data_error,
   output logic                    expected_toggle,
   output logic                    busy
);

   state_t                  state;
   state_t                  state_nxt;
   logic [6:0]              cnt;
   logic [15:0]             crc;
   logic [15:0]             crc_nxt;
   logic [15:0]             rx_crc;
   logic                    pid_tog;
   logic                    drop_err;
   logic [PAYLOAD_BITS-1:0] pay_buf;

   // result stage between CHECK and the output pulses
   logic                    res_ack;
   logic                    res_nak;
   logic                    res_load;

   logic                    take_pid;
   logic                    take_payload;
   logic                    take_crc_hi;
   logic                    take_crc_lo;
   logic                    early_fault;
   logic                    drop_fault;
   logic                    drop_err_set;
   logic                    drop_err_clr;
   logic                    chk_ack;
   logic                    chk_nak;
   logic                    chk_load;
   logic                    accept;

   crc16_d8 u_crc (
      .data     (rx_byte),
      .crc      (crc),
      .next_crc (crc_nxt)
   );

   assign busy = (state != ST_IDLE);

   always_comb begin
      state_nxt    = state;
      take_pid     = 1'b0;
      take_payload = 1'b0;
      take_crc_hi  = 1'b0;
      take_crc_lo  = 1'b0;
      early_fault  = 1'b0;
      drop_fault   = 1'b0;
      drop_err_set = 1'b0;
      drop_err_clr = 1'b0;
      chk_ack      = 1'b0;
      chk_nak      = 1'b0;
      chk_load     = 1'b0;
      accept       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (rx_valid) begin
               if (is_data_pid(rx_byte)) begin
                  if (rx_eop) begin
                     // PID-only packet: too short
                     early_fault = 1'b1;
                  end else begin
                     take_pid  = 1'b1;
                     state_nxt = ST_PAYLOAD;
                  end
               end else if (!rx_eop) begin
                  // unknown PID: swallow silently up to rx_eop
                  drop_err_clr = 1'b1;
                  state_nxt    = ST_DROP;
               end
            end
         end

         ST_PAYLOAD: begin
            if (rx_valid) begin
               if (rx_eop) begin
                  early_fault = 1'b1;
                  state_nxt   = ST_IDLE;
               end else begin
                  take_payload = 1'b1;
                  if (cnt == LAST_PAYLOAD) begin
                     state_nxt = ST_CRC_HI;
                  end
               end
            end
         end

         ST_CRC_HI: begin
            if (rx_valid) begin
               if (rx_eop) begin
                  early_fault = 1'b1;
                  state_nxt   = ST_IDLE;
               end else begin
                  take_crc_hi = 1'b1;
                  state_nxt   = ST_CRC_LO;
               end
            end
         end

         ST_CRC_LO: begin
            if (rx_valid) begin
               take_crc_lo = 1'b1;
               if (rx_eop) begin
                  state_nxt = ST_CHECK;
               end else begin
                  // overrun: report once the real end of packet shows up
                  drop_err_set = 1'b1;
                  state_nxt    = ST_DROP;
               end
            end
         end

         ST_CHECK: begin
            state_nxt = ST_IDLE;
            if (crc == rx_crc) begin
               chk_ack = 1'b1;
               if (pid_tog == expected_toggle) begin
                  chk_load  = 1'b1;
                  state_nxt = ST_HOLD;
               end
            end else begin
               chk_nak = 1'b1;
            end
         end

         ST_HOLD: begin
            if (data_valid && data_ready) begin
               accept    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end

         ST_DROP: begin
            if (rx_valid && rx_eop) begin
               drop_fault = drop_err;
               state_nxt  = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         crc             <= CRC16_INIT;
         rx_crc          <= '0;
         pid_tog         <= 1'b0;
         drop_err        <= 1'b0;
         pay_buf         <= '0;
         res_ack         <= 1'b0;
         res_nak         <= 1'b0;
         res_load        <= 1'b0;
         data            <= '0;
         data_valid      <= 1'b0;
         ack             <= 1'b0;
         nak             <= 1'b0;
         data_error      <= 1'b0;
         expected_toggle <= 1'b0;
      end else begin
         state <= state_nxt;

         if (take_pid) begin
            pid_tog <= (rx_byte == PID_DATA1);
            cnt     <= '0;
            crc     <= CRC16_INIT;
         end

         if (take_payload) begin
            cnt     <= cnt + 7'd1;
            crc     <= crc_nxt;
            pay_buf <= {pay_buf[PAYLOAD_BITS-9:0], rx_byte};
         end

         if (take_crc_hi) begin
            rx_crc[15:8] <= rx_byte;
         end
         if (take_crc_lo) begin
            rx_crc[7:0] <= rx_byte;
         end

         if (drop_err_set) begin
            drop_err <= 1'b1;
         end else if (drop_err_clr) begin
            drop_err <= 1'b0;
         end

         res_ack  <= chk_ack;
         res_nak  <= chk_nak;
         res_load <= chk_load;

         // CHECK results leave through one extra register stage; length
         // faults are reported straight from the byte that exposed them
         ack        <= res_ack;
         nak        <= res_nak | early_fault | drop_fault;
         data_error <= res_nak | early_fault | drop_fault;

         if (res_load) begin
            data            <= pay_buf;
            data_valid      <= 1'b1;
            expected_toggle <= ~expected_toggle;
         end else if (accept) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule
